// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
// Defaults are used by fifo_sync and fifo_mem.
package fifo_pkg;

  localparam int DEF_WORD_SIZE    = 10;
  localparam int DEF_DEPTH        = 8;
  localparam int DEF_ALMOST_FULL  = 6;
  localparam int DEF_ALMOST_EMPTY = 2;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register file for the FIFO.
// Provides one synchronous write port and one asynchronous read port, with no reset on the storage.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_SIZE,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO control: pointers, occupancy, registered flags.
// The optional sticky overflow/underflow flag is enabled by defining FIFO_ERROR_FLAG_EN.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int FIFO_WORD_SIZE     = DEF_WORD_SIZE,
  parameter int FIFO_DEPTH         = DEF_DEPTH,
  parameter int ALMOST_FULL_LEVEL  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY_LEVEL = DEF_ALMOST_EMPTY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      error
);

  localparam int AW = ptr_width(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LVL   = CW'(ALMOST_EMPTY_LEVEL);

  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count, count_next;
  logic                      push_ok, pop_ok;
  logic [FIFO_WORD_SIZE-1:0] rd_data;

  // A push into a full FIFO is still accepted when a pop frees the slot in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count        <= count_next;
      // Flags are computed from the next count so they never lag the counter.
      empty        <= (count_next == '0);
      full         <= (count_next == CNT_FULL);
      almost_full  <= (count_next >= AF_LVL);
      almost_empty <= (count_next <= AE_LVL);
    end
  end

  fifo_mem #(
    .WIDTH (FIFO_WORD_SIZE),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign data_out = empty ? '0 : rd_data;

`ifdef FIFO_ERROR_FLAG_EN
  logic error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if ((push && !push_ok) || (pop && !pop_ok)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The block SHALL have parameter FIFO_WORD_SIZE, default 10, meaning the data word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of entries; it must be a power of two and at least 4.
REQ-003 The block SHALL have parameter ALMOST_FULL_LEVEL, default 6, meaning the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter ALMOST_EMPTY_LEVEL, default 2, meaning the occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have these ports, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state changes on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  push  in  1  write request (write enable).
  data_in  in  FIFO_WORD_SIZE  word to write.
  pop  in  1  read request (read enable).
  data_out  out  FIFO_WORD_SIZE  head-of-queue word.
  empty  out  1  occupancy == 0.
  full  out  1  occupancy == FIFO_DEPTH.
  almost_full  out  1  occupancy >= ALMOST_FULL_LEVEL.
  almost_empty  out  1  occupancy <= ALMOST_EMPTY_LEVEL.
  error  out  1  sticky overflow/underflow flag (see Configuration).
REQ-006 The block SHALL have exactly one clock and one reset: the reset is asynchronous and active-high, and the ports are named clk and reset.

Function
REQ-007 Reads SHALL be first-word-fall-through: data_out shows the oldest stored word whenever empty=0, and pop consumes that word at the next rising edge.
REQ-008 A push SHALL be accepted when full=0, or when full=1 and pop=1 is accepted in the same cycle; the word is written at the tail and the write pointer advances.
REQ-009 A pop SHALL be accepted only when empty=0; a pop while empty is ignored and leaves the pointers unchanged.
REQ-010 When push and pop are both accepted in the same cycle, occupancy SHALL be unchanged and both pointers SHALL advance.
REQ-011 When empty=1 and push=1 and pop=1, only the push SHALL take effect.
REQ-012 Pointers SHALL be log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; the occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-013 empty, full, almost_full and almost_empty SHALL be registered and consistent with the occupancy after the same clock edge, i.e. zero-cycle flag lag relative to the occupancy counter.
REQ-014 A rejected push (full=1 and pop not accepted) SHALL NOT corrupt the stored data.
REQ-015 data_out SHALL be 0 when empty=1.

Reset
REQ-016 When reset is asserted, the block SHALL asynchronously set the pointers and occupancy to 0 and the outputs to empty=1, almost_empty=1, full=0, almost_full=0, error=0, data_out=0.
REQ-017 Memory contents SHALL NOT be cleared by reset, and SHALL be unobservable after reset until new words are written.
REQ-018 Reset asserted mid-operation SHALL discard all queued words, and any push or pop in that cycle SHALL be ignored.
REQ-019 After reset is released, the first push SHALL be accepted on the first rising edge.

Configuration
REQ-020 When macro FIFO_ERROR_FLAG_EN is defined, error SHALL set on any rejected push (overflow) or ignored pop (underflow) and SHALL hold until reset.
REQ-021 When FIFO_ERROR_FLAG_EN is undefined, error SHALL be tied to 0 and no detection logic SHALL be synthesized; the port list is unchanged.

Structure
REQ-022 Package fifo_pkg SHALL hold the default word size (10), default depth (8), the default threshold levels, and a function that computes the pointer width.
REQ-023 Storage SHALL be the sub-module fifo_mem, a dual-port register file with one synchronous write port and one asynchronous read port, instantiated once.
REQ-024 The control logic (pointers, counter, flags, error) SHALL reside in fifo_sync, and the design SHALL be synthesizable with no latches.

Verification
REQ-025 Reset check: push 10'h1A6 in the same cycle reset is released -> 10'h1A6 appears at data_out one edge later and empty=0.
REQ-026 Fill: push 8 words 10'h000..10'h007 -> almost_full rises after the 6th push, full rises after the 8th, and a 9th push (10'h3FF) is rejected with error=1 when the macro is defined.
REQ-027 Drain: pop 8 times from full -> data_out sequence 0..7 in order, almost_empty rises at occupancy 2, empty rises after the 8th pop, and a further pop sets error (macro defined) while data_out stays 0.
REQ-028 Simultaneous push and pop at full: push 10'h2B7 with pop -> occupancy stays 8, the head advances, and 10'h2B7 is read back 8 pops later.
REQ-029 Wrap-around: run 20 cycles of push+pop at occupancy 3 with incrementing data -> no loss or reordering across pointer wrap, and flags remain constant.
REQ-030 Mid-operation reset: at occupancy 5, pulse reset between clock edges -> empty=1 and full=0 immediately, and error clears.
